uart_rx_engine: RTL and testbench

//  Parametrised UART receive engine: oversampled serial deframer plus status-tagged RX FIFO.

---
 rtl/uart_rx_engine.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_engine.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_engine.sv
// uart_rx_engine: oversampled UART deframer feeding a status-tagged show-ahead RX FIFO.
// Optional character timeout is built when UART_RX_TIMEOUT_EN is defined.
module uart_rx_engine #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          baud_clk,
  input  logic                          rst,
  input  logic                          rx_en,
  input  logic                          data_in,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
  input  logic                          rd_en,
  input  logic                          clr_oe,
  output logic [DATA_BITS+2:0]          rd_data,
  output logic                          rx_empty,
  output logic                          rx_full,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          OE,
  output logic                          rx_busy,
  output logic                          rx_timeout
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = DATA_BITS + 3;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 pe_q, pe_d, fe_q, fe_d, z_q, z_d;
  logic                 sync1_q, sync2_q, prev_q;
  logic                 push, start_det, s, fall, mid, half, par_en;
  logic [WW-1:0]        wdata;

  assign s      = sync2_q;
  assign fall   = prev_q & ~sync2_q;
  assign mid    = cnt_q == CW'(OVERSAMPLE - 1);
  assign half   = cnt_q == CW'(OVERSAMPLE / 2 - 1);
  assign par_en = ^parity_mode;

  always_ff @(posedge baud_clk) begin
    if (rst) begin
      {sync1_q, sync2_q, prev_q} <= 3'b111;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      sync1_q <= data_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      z_q     <= z_d;
    end
  end

  // z tracks "every data/parity/stop sample so far was 0" for break detection
  always_comb begin
    state_d   = state_q;
    cnt_d     = mid ? '0 : cnt_q + 1'b1;
    bit_d     = bit_q;
    sh_d      = sh_q;
    pe_d      = pe_q;
    fe_d      = fe_q;
    z_d       = z_q;
    push      = 1'b0;
    start_det = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        start_det = fall;
        state_d   = fall ? START : IDLE;
      end
      START: if (half) begin
        state_d = s ? IDLE : DATA;
        cnt_d   = '0;
        bit_d   = '0;
        pe_d    = 1'b0;
        fe_d    = 1'b0;
        z_d     = 1'b1;
      end
      DATA: if (mid) begin
        sh_d  = {s, sh_q[DATA_BITS-1:1]};
        z_d   = z_q & ~s;
        bit_d = bit_q + 1'b1;
        if (bit_q == BW'(DATA_BITS - 1)) begin
          state_d = par_en ? PARITY : STOP;
          bit_d   = '0;
        end
      end
      PARITY: if (mid) begin
        pe_d    = ((^sh_q) ^ s) != parity_mode[1];
        z_d     = z_q & ~s;
        state_d = STOP;
      end
      STOP: if (mid) begin
        fe_d = fe_q | ~s;
        z_d  = z_q & ~s;
        if (stop2 && bit_q == '0) bit_d = 1'b1;
        else begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rx_en) begin
      state_d   = IDLE;
      push      = 1'b0;
      start_det = 1'b0;
    end
  end

  assign wdata   = {z_d, fe_d, pe_q, sh_q};
  assign rx_busy = state_q != IDLE;

  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q, rp_d;
  logic [LW-1:0] level_q, level_d;
  logic [WW-1:0] rd_q, head_d;
  logic          do_pop, do_push, ovr, oe_q;

  assign rx_empty = level_q == '0;
  assign rx_full  = level_q == LW'(FIFO_DEPTH);
  assign rx_level = level_q;
  assign rd_data  = rd_q;
  assign OE       = oe_q;
  assign do_pop   = rd_en & ~rx_empty;
  assign do_push  = push & (~rx_full | do_pop);
  assign ovr      = push & rx_full & ~do_pop;
  assign rp_d     = do_pop ? rp_q + 1'b1 : rp_q;
  assign level_d  = (do_push & ~do_pop) ? level_q + 1'b1 : (do_pop & ~do_push) ? level_q - 1'b1 : level_q;
  // a push landing on the new read pointer becomes the head directly
  assign head_d   = (do_push && wp_q == rp_d) ? wdata : mem[rp_d];

  always_ff @(posedge baud_clk) if (do_push) mem[wp_q] <= wdata;

  always_ff @(posedge baud_clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      rd_q    <= '0;
      oe_q    <= 1'b0;
    end else begin
      wp_q    <= do_push ? wp_q + 1'b1 : wp_q;
      rp_q    <= rp_d;
      level_q <= level_d;
      oe_q    <= ovr | (oe_q & ~clr_oe);
      if (do_pop || (do_push && rx_empty)) rd_q <= head_d;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int LIM = 4 * (DATA_BITS + 4) * OVERSAMPLE;
  localparam int TW  = $clog2(LIM + 1);
  logic [TW-1:0] to_q;
  always_ff @(posedge baud_clk) begin
    if (rst || do_push || rd_en || start_det) to_q <= '0;
    else if (!rx_empty && to_q != TW'(LIM)) to_q <= to_q + 1'b1;
  end
  assign rx_timeout = !rx_empty && to_q == TW'(LIM);
`else
  assign rx_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_engine.sv
// tb_uart_rx_engine: directed-vector bench for uart_rx_engine at default parameters.
module tb_uart_rx_engine;
  logic        baud_clk = 1'b0;
  logic        rst = 1'b1, rx_en = 1'b1, data_in = 1'b1, stop2 = 1'b0, rd_en = 1'b0, clr_oe = 1'b0;
  logic [1:0]  parity_mode = 2'b00;
  logic [10:0] rd_data;
  logic        rx_empty, rx_full, OE, rx_busy, rx_timeout;
  logic [4:0]  rx_level;
  int          vec = 0, miss = 0;

  uart_rx_engine dut (
    .baud_clk(baud_clk), .rst(rst), .rx_en(rx_en), .data_in(data_in), .parity_mode(parity_mode),
    .stop2(stop2), .rd_en(rd_en), .clr_oe(clr_oe), .rd_data(rd_data), .rx_empty(rx_empty),
    .rx_full(rx_full), .rx_level(rx_level), .OE(OE), .rx_busy(rx_busy), .rx_timeout(rx_timeout)
  );

  always #5 baud_clk = ~baud_clk;

  task automatic ticks(input int n);
    repeat (n) @(posedge baud_clk);
    #1;
  endtask

  // par < 0: no parity bit; nstop: 1 or 2 stop bits with values st; pop_at: tick to pulse rd_en
  task automatic send(input logic [7:0] d, input int par, input logic [1:0] st, input int nstop, input int pop_at);
    logic [15:0] v;
    int n;
    v = '1;
    v[0] = 1'b0;
    v[8:1] = d;
    n = 9;
    if (par >= 0) begin v[9] = par[0]; n = 10; end
    v[n] = st[0];
    v[n+1] = st[1];
    n = n + nstop;
    for (int i = 0; i < n * 16; i++) begin
      @(posedge baud_clk);
      #1;
      data_in = v[i/16];
      rd_en = (i == pop_at);
    end
    ticks(1);
    data_in = 1'b1;
    rd_en = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    ticks(1);
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    ticks(3);
    rst = 1'b0;
    ticks(1);
    vec++; if (rx_empty !== 1'b1) begin miss++; $display("FAIL reset_empty: got %b expected 1", rx_empty); end
    vec++; if (rx_full !== 1'b0) begin miss++; $display("FAIL reset_full: got %b expected 0", rx_full); end
    vec++; if (rx_level !== 5'd0) begin miss++; $display("FAIL reset_level: got %0d expected 0", rx_level); end
    vec++; if (OE !== 1'b0) begin miss++; $display("FAIL reset_oe: got %b expected 0", OE); end
    vec++; if (rx_busy !== 1'b0) begin miss++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
    vec++; if (rx_timeout !== 1'b0) begin miss++; $display("FAIL reset_timeout: got %b expected 0", rx_timeout); end
    vec++; if (rd_data !== 11'h000) begin miss++; $display("FAIL reset_rd_data: got %h expected 000", rd_data); end
  endtask

  task automatic test_basic();
    send(8'hA5, -1, 2'b11, 1, -1);
    vec++; if (rx_level !== 5'd1) begin miss++; $display("FAIL basic_level: got %0d expected 1", rx_level); end
    vec++; if (rd_data !== 11'h0A5) begin miss++; $display("FAIL basic_data: got %h expected 0a5", rd_data); end
    vec++; if (rx_busy !== 1'b0) begin miss++; $display("FAIL basic_busy: got %b expected 0", rx_busy); end
    pop();
    ticks(1);
    vec++; if (rx_empty !== 1'b1) begin miss++; $display("FAIL basic_pop_empty: got %b expected 1", rx_empty); end
  endtask

  task automatic test_parity_stop();
    parity_mode = 2'b01;
    send(8'h3C, 1, 2'b11, 1, -1);
    vec++; if (rd_data !== 11'h13C) begin miss++; $display("FAIL even_bad_parity: got %h expected 13c", rd_data); end
    pop();
    send(8'h3C, 0, 2'b11, 1, -1);
    vec++; if (rd_data !== 11'h03C) begin miss++; $display("FAIL even_good_parity: got %h expected 03c", rd_data); end
    pop();
    parity_mode = 2'b10;
    send(8'h3C, 1, 2'b11, 1, -1);
    vec++; if (rd_data !== 11'h03C) begin miss++; $display("FAIL odd_good_parity: got %h expected 03c", rd_data); end
    pop();
    parity_mode = 2'b00;
    send(8'h55, -1, 2'b10, 1, -1);
    vec++; if (rd_data !== 11'h255) begin miss++; $display("FAIL stop1_framing: got %h expected 255", rd_data); end
    pop();
    stop2 = 1'b1;
    send(8'h81, -1, 2'b01, 2, -1);
    vec++; if (rd_data !== 11'h281) begin miss++; $display("FAIL stop2_framing: got %h expected 281", rd_data); end
    pop();
    send(8'h81, -1, 2'b11, 2, -1);
    vec++; if (rd_data !== 11'h081) begin miss++; $display("FAIL stop2_good: got %h expected 081", rd_data); end
    pop();
    stop2 = 1'b0;
    ticks(1);
    vec++; if (rx_empty !== 1'b1) begin miss++; $display("FAIL parity_drained: got %b expected 1", rx_empty); end
  endtask

  task automatic test_break();
    data_in = 1'b0;
    ticks(192);
    data_in = 1'b1;
    ticks(40);
    vec++; if (rx_level !== 5'd1) begin miss++; $display("FAIL break_level: got %0d expected 1", rx_level); end
    vec++; if (rd_data !== 11'h600) begin miss++; $display("FAIL break_data: got %h expected 600", rd_data); end
    pop();
    ticks(200);
    vec++; if (rx_empty !== 1'b1) begin miss++; $display("FAIL break_no_second: got %b expected 1", rx_empty); end
  endtask

  task automatic test_glitch();
    data_in = 1'b0;
    ticks(4);
    data_in = 1'b1;
    vec++; if (rx_busy !== 1'b1) begin miss++; $display("FAIL glitch_busy: got %b expected 1", rx_busy); end
    ticks(30);
    vec++; if (rx_busy !== 1'b0) begin miss++; $display("FAIL glitch_idle: got %b expected 0", rx_busy); end
    vec++; if (rx_empty !== 1'b1) begin miss++; $display("FAIL glitch_empty: got %b expected 1", rx_empty); end
  endtask

  task automatic test_rx_en();
    data_in = 1'b0;
    ticks(50);
    vec++; if (rx_busy !== 1'b1) begin miss++; $display("FAIL rxen_busy: got %b expected 1", rx_busy); end
    rx_en = 1'b0;
    ticks(2);
    vec++; if (rx_busy !== 1'b0) begin miss++; $display("FAIL rxen_abort: got %b expected 0", rx_busy); end
    data_in = 1'b1;
    ticks(2);
    rx_en = 1'b1;
    ticks(200);
    vec++; if (rx_empty !== 1'b1) begin miss++; $display("FAIL rxen_no_push: got %b expected 1", rx_empty); end
  endtask

  task automatic test_overrun();
    logic [10:0] exp;
    for (int i = 0; i < 17; i++) send(8'h10 + 8'(i), -1, 2'b11, 1, -1);
    vec++; if (rx_full !== 1'b1) begin miss++; $display("FAIL ovr_full: got %b expected 1", rx_full); end
    vec++; if (rx_level !== 5'd16) begin miss++; $display("FAIL ovr_level: got %0d expected 16", rx_level); end
    vec++; if (OE !== 1'b1) begin miss++; $display("FAIL ovr_oe: got %b expected 1", OE); end
    vec++; if (rd_data !== 11'h010) begin miss++; $display("FAIL ovr_head: got %h expected 010", rd_data); end
    ticks(20);
    vec++; if (OE !== 1'b1) begin miss++; $display("FAIL ovr_sticky: got %b expected 1", OE); end
    clr_oe = 1'b1;
    ticks(1);
    clr_oe = 1'b0;
    vec++; if (OE !== 1'b0) begin miss++; $display("FAIL ovr_clear: got %b expected 0", OE); end
    send(8'hEE, -1, 2'b11, 1, 154);
    vec++; if (OE !== 1'b0) begin miss++; $display("FAIL full_pushpop_oe: got %b expected 0", OE); end
    vec++; if (rx_level !== 5'd16) begin miss++; $display("FAIL full_pushpop_level: got %0d expected 16", rx_level); end
    for (int i = 0; i < 16; i++) begin
      exp = (i == 15) ? 11'h0EE : 11'h011 + 11'(i);
      vec++; if (rd_data !== exp) begin miss++; $display("FAIL drain_%0d: got %h expected %h", i, rd_data, exp); end
      pop();
    end
    ticks(1);
    vec++; if (rx_empty !== 1'b1) begin miss++; $display("FAIL drain_empty: got %b expected 1", rx_empty); end
    pop();
    ticks(1);
    vec++; if (rx_level !== 5'd0) begin miss++; $display("FAIL pop_empty_level: got %0d expected 0", rx_level); end
  endtask

  task automatic test_timeout();
    send(8'h42, -1, 2'b11, 1, -1);
    ticks(700);
    vec++; if (rx_timeout !== 1'b0) begin miss++; $display("FAIL timeout_early: got %b expected 0", rx_timeout); end
    ticks(100);
`ifdef UART_RX_TIMEOUT_EN
    vec++; if (rx_timeout !== 1'b1) begin miss++; $display("FAIL timeout_set: got %b expected 1", rx_timeout); end
`else
    vec++; if (rx_timeout !== 1'b0) begin miss++; $display("FAIL timeout_tied: got %b expected 0", rx_timeout); end
`endif
    pop();
    ticks(1);
    vec++; if (rx_timeout !== 1'b0) begin miss++; $display("FAIL timeout_clear: got %b expected 0", rx_timeout); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_stop();
    test_break();
    test_glitch();
    test_rx_en();
    test_overrun();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
